// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: 68k-style bus controller with region decode, wait states, bus error and interrupt priority encoding.
module cpu_bus_ctrl #(
    parameter int ROM_WAIT    = 2,
    parameter int RAM_WAIT    = 1,
    parameter int IO_WAIT     = 3,
    parameter int BERR_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] cpu_a,
    input  logic        cpu_as_n,
    input  logic        cpu_r_w_n,
    input  logic [2:0]  cpu_fc,
    input  logic [6:0]  irq_req,
    output logic        cpu_dtack_n,
    output logic        cpu_vpa_n,
    output logic        cpu_berr_n,
    output logic [2:0]  cpu_ipl,
    output logic        sel_rom,
    output logic        sel_ram,
    output logic        sel_io
);
    typedef enum logic [2:0] {IDLE, DECODE, WAIT, ACK, ERR} state_t;
    state_t      state, state_d;
    logic [23:0] a_q;
    logic [2:0]  fc_q;
    logic        rw_q;
    logic [7:0]  cnt, cnt_d, w;
    logic [6:0]  pending, irq_prev, clr;
    logic [7:0]  lvl_oh;
    logic [2:0]  hi;
    logic        iack, rom, ram, io, mapped, busy;
    logic        unused_bits;
    assign unused_bits = ^{rw_q, a_q[13:4], a_q[0]};
    assign iack   = fc_q == 3'b111;
    assign rom    = a_q[23:16] == 8'd0;
    assign ram    = a_q[23:14] == 10'd5 || a_q[23:14] == 10'd6;
    assign io     = a_q[23:21] == 3'b100;
    assign mapped = rom | ram | io;
    assign w      = rom ? 8'(ROM_WAIT) : ram ? 8'(RAM_WAIT) : 8'(IO_WAIT);
    assign lvl_oh = 8'd1 << a_q[3:1];
    assign busy   = (state_d == WAIT || state_d == ACK) && !iack;
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE:   state_d = cpu_as_n ? IDLE : DECODE;
            DECODE: begin
                if (cpu_as_n)
                    state_d = IDLE;
                else if (iack)
                    state_d = ACK;
                else if (mapped) begin
                    state_d = (w == 8'd0) ? ACK : WAIT;
                    cnt_d   = w;
                end else begin
                    state_d = ERR;
                    cnt_d   = 8'(BERR_CYCLES);
                end
            end
            WAIT: begin
                if (cpu_as_n)
                    state_d = IDLE;
                else if (cnt == 8'd1)
                    state_d = ACK;
                cnt_d = cnt - 8'd1;
            end
            ACK:    state_d = cpu_as_n ? IDLE : ACK;
            ERR: begin
                state_d = cpu_as_n ? IDLE : ERR;
                cnt_d   = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE || state_d == ACK)
            cnt_d = 8'd0;
    end
    // The acknowledged level's pending bit drops as the IACK cycle is acknowledged.
    assign clr = (state == DECODE && state_d == ACK && iack) ? lvl_oh[7:1] : 7'd0;
    always_comb begin
        hi = 3'd0;
        for (int i = 0; i < 7; i++)
            if (pending[i]) hi = 3'(i + 1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            a_q         <= 24'd0;
            fc_q        <= 3'd0;
            rw_q        <= 1'b1;
            pending     <= 7'd0;
            irq_prev    <= 7'd0;
            cpu_ipl     <= 3'b111;
            cpu_dtack_n <= 1'b1;
            cpu_vpa_n   <= 1'b1;
            cpu_berr_n  <= 1'b1;
            sel_rom     <= 1'b0;
            sel_ram     <= 1'b0;
            sel_io      <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == IDLE && !cpu_as_n) begin
                a_q  <= cpu_a;
                fc_q <= cpu_fc;
                rw_q <= cpu_r_w_n;
            end
            pending     <= (pending & ~clr) | (irq_req & ~irq_prev);
            irq_prev    <= irq_req;
            cpu_ipl     <= ~hi;
            cpu_dtack_n <= !(state_d == ACK && !iack);
            cpu_vpa_n   <= !(state_d == ACK && iack);
            cpu_berr_n  <= !(state_d == ERR && cnt_d == 8'd0);
            sel_rom     <= busy && rom;
            sel_ram     <= busy && ram;
            sel_io      <= busy && io;
        end
    end
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb_cpu_bus_ctrl: directed and random bus cycles checked against a cycle-offset timing model.
module tb_cpu_bus_ctrl;
    localparam int ROM_W = 2, RAM_W = 1, IO_W = 3, BERR = 16;
    logic        clk = 1'b0, reset, cpu_as_n, cpu_r_w_n;
    logic [23:0] cpu_a;
    logic [2:0]  cpu_fc;
    logic [6:0]  irq_req;
    logic        dtack_n, vpa_n, berr_n, s_rom, s_ram, s_io;
    logic        dtack_n0, vpa_n0, berr_n0, s_rom0, s_ram0, s_io0;
    logic [2:0]  ipl, ipl0;
    int          checks = 0, errors = 0;
    logic [6:0]  pend_m = 7'd0, prev_m = 7'd0;
    logic [2:0]  ipl_m = 3'b111;

    always #5 clk = ~clk;

    cpu_bus_ctrl dut (
        .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_as_n(cpu_as_n), .cpu_r_w_n(cpu_r_w_n),
        .cpu_fc(cpu_fc), .irq_req(irq_req), .cpu_dtack_n(dtack_n), .cpu_vpa_n(vpa_n),
        .cpu_berr_n(berr_n), .cpu_ipl(ipl), .sel_rom(s_rom), .sel_ram(s_ram), .sel_io(s_io)
    );
    cpu_bus_ctrl #(.RAM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_as_n(cpu_as_n), .cpu_r_w_n(cpu_r_w_n),
        .cpu_fc(cpu_fc), .irq_req(irq_req), .cpu_dtack_n(dtack_n0), .cpu_vpa_n(vpa_n0),
        .cpu_berr_n(berr_n0), .cpu_ipl(ipl0), .sel_rom(s_rom0), .sel_ram(s_ram0), .sel_io(s_io0)
    );

    function automatic logic [2:0] top_lvl(logic [6:0] p);
        for (int l = 7; l >= 1; l--)
            if (p[l-1]) return 3'(l);
        return 3'd0;
    endfunction

    // Expected {dtack_n, vpa_n, berr_n, sel_rom, sel_ram, sel_io} after edge k+t of a cycle held for n edges.
    function automatic logic [5:0] exp_out(int t, int n, logic [23:0] a, logic [2:0] fc, int ram_w);
        int w;
        logic [2:0] sel;
        if (t == 0 || t >= n) return 6'b111000;
        if (fc == 3'b111) return 6'b101000;
        if (a <= 24'h00FFFF) begin w = ROM_W; sel = 3'b100; end
        else if (a >= 24'h014000 && a <= 24'h01BFFF) begin w = ram_w; sel = 3'b010; end
        else if (a >= 24'h800000 && a <= 24'h9FFFFF) begin w = IO_W; sel = 3'b001; end
        else return {2'b11, (t >= 1 + BERR) ? 1'b0 : 1'b1, 3'b000};
        return {(t >= 1 + w) ? 1'b0 : 1'b1, 2'b11, sel};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input logic [5:0] e, input logic [5:0] e0, input string tag);
        chk({tag, ":out"}, {2'b0, dtack_n, vpa_n, berr_n, s_rom, s_ram, s_io}, {2'b0, e});
        chk({tag, ":out_ram0"}, {2'b0, dtack_n0, vpa_n0, berr_n0, s_rom0, s_ram0, s_io0}, {2'b0, e0});
        chk({tag, ":ipl"}, {5'b0, ipl}, {5'b0, ipl_m});
        chk({tag, ":ipl_ram0"}, {5'b0, ipl0}, {5'b0, ipl_m});
        chk({tag, ":one_strobe"}, {7'b0, $countones({dtack_n, vpa_n, berr_n}) >= 2}, 8'd1);
    endtask

    task automatic step(input int clr_lvl);
        if (reset) begin
            pend_m = 7'd0; prev_m = 7'd0; ipl_m = 3'b111;
        end else begin
            ipl_m = ~top_lvl(pend_m);
            if (clr_lvl != 0) pend_m[clr_lvl-1] = 1'b0;
            pend_m = pend_m | (irq_req & ~prev_m);
            prev_m = irq_req;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cpu_as_n = 1'b1;
        repeat (n) begin
            step(0);
            check_all(6'b111000, 6'b111000, "idle");
        end
    endtask

    task automatic txn(input logic [23:0] a, input logic [2:0] fc, input int n,
                       input logic [6:0] irq1, input int rst_at);
        cpu_a = a; cpu_fc = fc; cpu_r_w_n = 1'($urandom);
        for (int t = 0; t <= n; t++) begin
            if (t == 1) irq_req = irq1;
            cpu_as_n = (t == n);
            if (t == rst_at) reset = 1'b1;
            step((t == 1 && n > 1 && fc == 3'b111) ? int'(a[3:1]) : 0);
            if (t == rst_at) begin
                check_all(6'b111000, 6'b111000, "mid_reset");
                reset = 1'b0;
                break;
            end
            check_all(exp_out(t, n, a, fc, RAM_W), exp_out(t, n, a, fc, 0),
                      $sformatf("a%06h_fc%0d_t%0d", a, fc, t));
        end
        cpu_as_n = 1'b1;
        cpu_a = 24'($urandom);
    endtask

    initial begin
        reset = 1'b1; cpu_as_n = 1'b1; cpu_r_w_n = 1'b1; cpu_a = 24'd0; cpu_fc = 3'd0; irq_req = 7'd0;
        step(0);
        check_all(6'b111000, 6'b111000, "reset");
        reset = 1'b0;
        idle(2);
        txn(24'h000100, 3'b101, 5, 7'd0, -1); idle(1);
        txn(24'h014000, 3'b101, 3, 7'd0, -1); idle(1);
        txn(24'h800000, 3'b101, 6, 7'd0, -1); idle(1);
        txn(24'h400000, 3'b101, 20, 7'd0, -1); idle(1);
        irq_req = 7'b0010010; idle(1);
        irq_req = 7'd0; idle(2);
        chk("ipl_levels_2_5", {5'b0, ipl}, 8'b010);
        txn(24'h00000A, 3'b111, 3, 7'd0, -1); idle(2);
        chk("ipl_after_iack5", {5'b0, ipl}, 8'b101);
        txn(24'h000004, 3'b111, 3, 7'd0, -1); idle(2);
        chk("ipl_after_iack2", {5'b0, ipl}, 8'b111);
        txn(24'h00000E, 3'b111, 3, 7'd0, -1); idle(1);
        irq_req = 7'b0000100; idle(1);
        irq_req = 7'd0; idle(1);
        txn(24'h000006, 3'b111, 3, 7'b0000100, -1);
        irq_req = 7'd0; idle(2);
        chk("ipl_rise_wins", {5'b0, ipl}, 8'b100);
        txn(24'h000006, 3'b111, 3, 7'd0, -1); idle(2);
        chk("ipl_cleared3", {5'b0, ipl}, 8'b111);
        txn(24'h000200, 3'b110, 2, 7'd0, -1); idle(1);
        txn(24'h000200, 3'b110, 1, 7'd0, -1); idle(1);
        txn(24'h400010, 3'b101, 5, 7'd0, -1); idle(1);
        irq_req = 7'b1000000; idle(1);
        irq_req = 7'd0; idle(1);
        txn(24'h000300, 3'b110, 8, 7'd0, 4); idle(2);
        for (int i = 0; i < 80; i++) begin
            logic [23:0] a;
            logic [2:0]  fc;
            case ($urandom_range(0, 4))
                0: a = 24'($urandom_range(0, 32'h00FFFF));
                1: a = 24'($urandom_range(32'h014000, 32'h01BFFF));
                2: a = 24'($urandom_range(32'h800000, 32'h9FFFFF));
                3: a = 24'($urandom_range(32'h010000, 32'h014010));
                default: a = 24'($urandom);
            endcase
            fc = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) irq_req = 7'($urandom);
            txn(a, fc, $urandom_range(1, 22), ($urandom_range(0, 3) == 0) ? 7'($urandom) : irq_req,
                ($urandom_range(0, 19) == 0) ? $urandom_range(1, 6) : -1);
            idle($urandom_range(1, 2));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
